// File: rtl/beat_pulse_conditioner.sv
// Heartbeat front end: synchronizes and debounces the raw sensor pulse, applies a
// refractory window, and emits one strobe per accepted beat plus glitch/asystole status.
module beat_pulse_conditioner #(
    parameter int DEBOUNCE_MS = 8,
    parameter int REFRACT_MS  = 250,
    parameter int TIMEOUT_MS  = 3000,
    parameter int CNT_W       = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1ms,
    input  logic       pulse_raw,
    output logic       beat_pulse,
    output logic       beat_level,
    output logic       asystole_flag,
    output logic [7:0] rejected_count
);
    localparam logic [1:0] ARMED    = 2'd0;
    localparam logic [1:0] DEB_HI   = 2'd1;
    localparam logic [1:0] REFRACT  = 2'd2;
    localparam logic [1:0] WAIT_LOW = 2'd3;

    localparam logic [CNT_W-1:0] DEB_END = CNT_W'(DEBOUNCE_MS);
    localparam logic [CNT_W-1:0] REF_END = CNT_W'(REFRACT_MS);
    localparam logic [CNT_W-1:0] TO_END  = CNT_W'(TIMEOUT_MS);

    logic             sync_q1, sync_in, sync_prev;
    logic [1:0]       state;
    logic [CNT_W-1:0] deb_cnt, ref_cnt, to_cnt;
    logic [CNT_W-1:0] deb_nxt, ref_nxt;
    logic             reject;

    assign deb_nxt = deb_cnt + CNT_W'(1);
    assign ref_nxt = ref_cnt + CNT_W'(1);

    // An abort in DEB_HI wins over a coincident tick, so a falling input never counts.
    always_comb begin
        reject = 1'b0;
        if (state == DEB_HI && !sync_in)
            reject = 1'b1;
        if (state == REFRACT && sync_in && !sync_prev)
            reject = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1   <= 1'b0;
            sync_in   <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync_q1   <= pulse_raw;
            sync_in   <= sync_q1;
            sync_prev <= sync_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ARMED;
            deb_cnt        <= '0;
            ref_cnt        <= '0;
            beat_pulse     <= 1'b0;
            beat_level     <= 1'b0;
            rejected_count <= 8'd0;
        end else begin
            beat_pulse <= 1'b0;
            if (reject && rejected_count != 8'hFF)
                rejected_count <= rejected_count + 8'd1;
            case (state)
                ARMED: begin
                    if (sync_in) begin
                        state   <= DEB_HI;
                        deb_cnt <= '0;
                    end
                end
                DEB_HI: begin
                    if (!sync_in) begin
                        state <= ARMED;
                    end else if (tick_1ms) begin
                        deb_cnt <= deb_nxt;
                        if (deb_nxt == DEB_END) begin
                            state      <= REFRACT;
                            ref_cnt    <= '0;
                            beat_level <= 1'b1;
                            beat_pulse <= 1'b1;
                        end
                    end
                end
                REFRACT: begin
                    if (!sync_in)
                        beat_level <= 1'b0;
                    if (tick_1ms) begin
                        ref_cnt <= ref_nxt;
                        if (ref_nxt == REF_END)
                            state <= sync_in ? WAIT_LOW : ARMED;
                    end
                end
                WAIT_LOW: begin
                    if (!sync_in) begin
                        beat_level <= 1'b0;
                        state      <= ARMED;
                    end
                end
                default: state <= ARMED;
            endcase
        end
    end

    // A beat clears the timeout even when a tick lands on the same clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            to_cnt <= '0;
        else if (beat_pulse)
            to_cnt <= '0;
        else if (tick_1ms && to_cnt != TO_END)
            to_cnt <= to_cnt + CNT_W'(1);
    end

    assign asystole_flag = (to_cnt == TO_END);

endmodule

// File: tb/tb_beat_pulse_conditioner.sv
// Directed bench for beat_pulse_conditioner; tick_1ms is compressed to one pulse every 4 clks.
module tb_beat_pulse_conditioner;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1ms = 1'b0;
    logic       pulse_raw = 1'b0;
    logic       beat_pulse, beat_level, asystole_flag;
    logic [7:0] rejected_count;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, ntick = 0, nbeats = 0, last_beat = -1;
    int rise, b0;

    always #5 clk = ~clk;

    beat_pulse_conditioner dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tick_1ms      (tick_1ms),
        .pulse_raw     (pulse_raw),
        .beat_pulse    (beat_pulse),
        .beat_level    (beat_level),
        .asystole_flag (asystole_flag),
        .rejected_count(rejected_count)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // One clk: sample 1 time unit after the edge, then schedule the next tick.
    task automatic step();
        logic t;
        t = tick_1ms;
        @(posedge clk);
        #1;
        cyc++;
        if (t) ntick++;
        if (beat_pulse === 1'b1) begin
            nbeats++;
            last_beat = cyc;
        end
        tick_1ms = (cyc % 4 == 0);
    endtask

    task automatic ticks(input int n);
        int target;
        target = ntick + n;
        while (ntick < target) step();
    endtask

    task automatic align();
        while (cyc % 4 != 0) step();
    endtask

    task automatic check_zero(input string tag);
        check({tag, " beat_pulse"}, 32'(beat_pulse), 0);
        check({tag, " beat_level"}, 32'(beat_level), 0);
        check({tag, " asystole"}, 32'(asystole_flag), 0);
        check({tag, " rejected"}, 32'(rejected_count), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pulse_raw = 1'b0;
        step();
        step();
        check_zero("reset");
        rst_n = 1'b1;
        ntick = 0;
    endtask

    task automatic wait_beat(input string tag, input int budget);
        int start, k;
        start = nbeats;
        k = 0;
        while (nbeats == start && k < budget) begin
            step();
            k++;
        end
        check({tag, " beat seen"}, 32'(nbeats - start), 1);
    endtask

    initial begin
        // 1: clean 20-tick pulse, latency 3 clk to DEB_HI, 8 ticks at 4-clk spacing, +1 clk
        do_reset();
        align();
        pulse_raw = 1'b1;
        rise = cyc;
        ticks(20);
        check("t1 beats", 32'(nbeats), 1);
        check("t1 latency", 32'(last_beat - rise), 33);
        check("t1 level high", 32'(beat_level), 1);
        pulse_raw = 1'b0;
        step();
        step();
        check("t1 level held", 32'(beat_level), 1);
        step();
        check("t1 level low", 32'(beat_level), 0);
        check("t1 rejected", 32'(rejected_count), 0);
        ticks(260);

        // 2: short glitches rejected, counter saturates
        pulse_raw = 1'b1;
        ticks(5);
        pulse_raw = 1'b0;
        ticks(5);
        check("t2 rej one", 32'(rejected_count), 1);
        for (int i = 0; i < 299; i++) begin
            pulse_raw = 1'b1;
            ticks(5);
            pulse_raw = 1'b0;
            ticks(2);
        end
        check("t2 rej sat", 32'(rejected_count), 255);
        check("t2 beats", 32'(nbeats), 1);

        // 3: pulse inside refractory window ignored, later pulse accepted
        do_reset();
        b0 = nbeats;
        align();
        pulse_raw = 1'b1;
        ticks(20);
        pulse_raw = 1'b0;
        ticks(80);
        pulse_raw = 1'b1;
        ticks(20);
        pulse_raw = 1'b0;
        check("t3 refract beats", 32'(nbeats - b0), 1);
        check("t3 refract rej", 32'(rejected_count), 1);
        ticks(280);
        pulse_raw = 1'b1;
        ticks(20);
        pulse_raw = 1'b0;
        check("t3 third beats", 32'(nbeats - b0), 2);
        check("t3 third rej", 32'(rejected_count), 1);
        ticks(300);

        // 4: long high gives one beat; re-arm needs a low
        b0 = nbeats;
        pulse_raw = 1'b1;
        ticks(1000);
        check("t4 long beats", 32'(nbeats - b0), 1);
        check("t4 long level", 32'(beat_level), 1);
        pulse_raw = 1'b0;
        ticks(3);
        check("t4 level low", 32'(beat_level), 0);
        pulse_raw = 1'b1;
        ticks(20);
        pulse_raw = 1'b0;
        check("t4 rearm beats", 32'(nbeats - b0), 2);
        check("t4 rej", 32'(rejected_count), 1);
        ticks(300);

        // 5: asystole at exactly 3000 ticks, cleared the clk after a beat
        do_reset();
        ticks(2999);
        check("t5 flag 2999", 32'(asystole_flag), 0);
        ticks(1);
        check("t5 flag 3000", 32'(asystole_flag), 1);
        ticks(2000);
        check("t5 flag 5000", 32'(asystole_flag), 1);
        align();
        pulse_raw = 1'b1;
        wait_beat("t5", 200);
        check("t5 flag at beat", 32'(asystole_flag), 1);
        step();
        check("t5 flag after beat", 32'(asystole_flag), 0);
        pulse_raw = 1'b0;
        ticks(300);

        // 6: reset mid-debounce (deb_cnt=5) kills the pending beat
        do_reset();
        b0 = nbeats;
        align();
        pulse_raw = 1'b1;
        repeat (21) step();
        rst_n = 1'b0;
        #1;
        check_zero("t6 async");
        pulse_raw = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        ticks(20);
        check("t6 no beat", 32'(nbeats - b0), 0);
        align();
        pulse_raw = 1'b1;
        rise = cyc;
        ticks(20);
        pulse_raw = 1'b0;
        check("t6 next beats", 32'(nbeats - b0), 1);
        check("t6 next latency", 32'(last_beat - rise), 33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
